fm_discriminator: RTL and testbench

FM_DISCRIMINATOR -- requirements
Module: fm_discriminator

---
 rtl/fm_pkg.sv | 30 +++
 rtl/axis_skid_buffer.sv | 65 ++++++
 rtl/fm_discriminator.sv | 140 ++++++++++++++
 tb/tb_fm_discriminator.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fm_pkg.sv
// Shared types, tdata field offsets and the saturation helper for the FM discriminator.
package fm_pkg;

  typedef enum logic [1:0] {
    ST_PRIME = 2'd0,
    ST_ACCUM = 2'd1,
    ST_EMIT  = 2'd2
  } fm_state_e;

  localparam int PHASE_MSB = 31;
  localparam int PHASE_LSB = 16;
  localparam int MAG_MSB   = 15;
  localparam int MAG_LSB   = 0;

  // Clamp to the signed range of an out_w-bit word; result is sign-extended to 32 bits.
  function automatic logic signed [31:0] sat_to_width(input logic signed [63:0] val,
                                                      input int unsigned out_w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (val > hi) begin
      return hi[31:0];
    end else if (val < lo) begin
      return lo[31:0];
    end
    return val[31:0];
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry skid buffer with registered outputs; push and pop may coincide.
module axis_skid_buffer #(
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic [1:0]       occ_q, occ_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic             push, pop;

  assign in_ready  = (occ_q != 2'd2);
  assign out_valid = (occ_q != 2'd0);
  assign out_data  = head_q;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    unique case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) head_d = in_data;
        else               tail_d = in_data;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        if (occ_q == 2'd2) head_d = tail_q;
        occ_d = occ_q - 2'd1;
      end
      2'b11: begin
        // Occupancy holds; the incoming word lands behind whatever remains.
        if (occ_q == 2'd1) begin
          head_d = in_data;
        end else begin
          head_d = tail_q;
          tail_d = in_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q  <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

endmodule

// File: rtl/fm_discriminator.sv
// Polar-to-frequency discriminator: wrapped phase differences are squelched,
// summed over DECIM beats (or up to tlast), scaled, saturated and streamed out.
module fm_discriminator
  import fm_pkg::*;
#(
  parameter int          ANGLE_W    = 16,
  parameter int          OUT_W      = 16,
  parameter int          DECIM      = 4,
  parameter int          SHIFT      = 1,
  parameter logic [15:0] MAG_THRESH = 16'h0000
) (
  input  logic        s00_axis_aclk,
  input  logic        s00_axis_aresetn,
  input  logic        s00_axis_tvalid,
  output logic        s00_axis_tready,
  input  logic [31:0] s00_axis_tdata,
  input  logic        s00_axis_tlast,
  input  logic [3:0]  s00_axis_tstrb,
  output logic        m00_axis_tvalid,
  input  logic        m00_axis_tready,
  output logic [31:0] m00_axis_tdata,
  output logic        m00_axis_tlast,
  output logic [3:0]  m00_axis_tstrb
);

  localparam int ACC_W = ANGLE_W + $clog2(DECIM) + 1;
  localparam int CNT_W = $clog2(DECIM + 1);

  fm_state_e                 state_q, state_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [ANGLE_W-1:0]        prev_q, prev_d;
  logic                      last_q, last_d;
  logic                      rdy_en_q, rdy_en_d;

  logic [ANGLE_W-1:0]        phase_in;
  logic [15:0]               mag_in;
  logic [16:0]               mag_diff;
  logic                      squelch;
  logic signed [ANGLE_W-1:0] delta;
  logic signed [ACC_W-1:0]   delta_ext;
  logic [CNT_W-1:0]          cnt_inc;
  logic                      beat_fire, close_grp;
  logic signed [ACC_W-1:0]   acc_shr;
  logic signed [31:0]        sat_word;
  logic                      buf_push, buf_in_ready, buf_out_valid;
  logic [OUT_W:0]            buf_din, buf_dout;
  logic                      unused_bits;

  assign phase_in  = s00_axis_tdata[PHASE_MSB -: ANGLE_W];
  assign mag_in    = s00_axis_tdata[MAG_MSB:MAG_LSB];
  assign mag_diff  = {1'b0, mag_in} - {1'b0, MAG_THRESH};
  assign squelch   = mag_diff[16];
  assign delta     = squelch ? '0 : (phase_in - prev_q);
  assign delta_ext = {{(ACC_W - ANGLE_W){delta[ANGLE_W-1]}}, delta};
  assign cnt_inc   = cnt_q + CNT_W'(1);
  assign close_grp = s00_axis_tlast || (cnt_inc == CNT_W'(DECIM));

  // rdy_en_q keeps tready low until the first edge after reset release.
  assign s00_axis_tready = rdy_en_q && (state_q != ST_EMIT) && buf_in_ready;
  assign beat_fire       = s00_axis_tvalid && s00_axis_tready;
  assign rdy_en_d        = 1'b1;

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) state_q <= ST_PRIME;
    else                   state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_PRIME, ST_ACCUM: begin
        if (beat_fire) state_d = close_grp ? ST_EMIT : ST_ACCUM;
      end
      ST_EMIT: state_d = last_q ? ST_PRIME : ST_ACCUM;
      default: state_d = ST_PRIME;
    endcase
  end

  assign acc_shr  = acc_q >>> SHIFT;
  assign sat_word = sat_to_width({{(64 - ACC_W){acc_shr[ACC_W-1]}}, acc_shr}, OUT_W);

  always_comb begin
    buf_push = (state_q == ST_EMIT);
    buf_din  = {last_q, sat_word[OUT_W-1:0]};
  end

  always_comb begin
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    prev_d = prev_q;
    last_d = last_q;
    if (state_q == ST_EMIT) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (beat_fire) begin
      prev_d = phase_in;
      cnt_d  = cnt_inc;
      last_d = s00_axis_tlast;
      acc_d  = (state_q == ST_PRIME) ? '0 : (acc_q + delta_ext);
    end
  end

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      prev_q   <= '0;
      last_q   <= 1'b0;
      rdy_en_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      prev_q   <= prev_d;
      last_q   <= last_d;
      rdy_en_q <= rdy_en_d;
    end
  end

  axis_skid_buffer #(
    .WIDTH(OUT_W + 1)
  ) u_skid (
    .clk      (s00_axis_aclk),
    .rst_n    (s00_axis_aresetn),
    .in_valid (buf_push),
    .in_ready (buf_in_ready),
    .in_data  (buf_din),
    .out_valid(buf_out_valid),
    .out_ready(m00_axis_tready),
    .out_data (buf_dout)
  );

  assign m00_axis_tvalid = buf_out_valid;
  assign m00_axis_tlast  = buf_dout[OUT_W];
  assign m00_axis_tdata  = {{(32 - OUT_W){buf_dout[OUT_W-1]}}, buf_dout[OUT_W-1:0]};
  assign m00_axis_tstrb  = 4'hF;

  assign unused_bits = ^{s00_axis_tstrb, s00_axis_tdata, sat_word};

endmodule

// File: tb/tb_fm_discriminator.sv
// Bench for fm_discriminator: instance 0 is DECIM=1/SHIFT=1, instance 1 is
// DECIM=4/SHIFT=0/MAG_THRESH=0x100; a reference model predicts every output word.
module tb_fm_discriminator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n    [2];
  logic        s_tvalid [2];
  logic        s_tready [2];
  logic [31:0] s_tdata  [2];
  logic        s_tlast  [2];
  logic [3:0]  s_tstrb;
  logic        m_tvalid [2];
  logic        m_tready [2];
  logic [31:0] m_tdata  [2];
  logic        m_tlast  [2];
  logic [3:0]  m_tstrb  [2];

  fm_discriminator #(
    .ANGLE_W(16), .OUT_W(16), .DECIM(1), .SHIFT(1), .MAG_THRESH(16'h0000)
  ) dut_a (
    .s00_axis_aclk(clk), .s00_axis_aresetn(rst_n[0]),
    .s00_axis_tvalid(s_tvalid[0]), .s00_axis_tready(s_tready[0]),
    .s00_axis_tdata(s_tdata[0]), .s00_axis_tlast(s_tlast[0]), .s00_axis_tstrb(s_tstrb),
    .m00_axis_tvalid(m_tvalid[0]), .m00_axis_tready(m_tready[0]),
    .m00_axis_tdata(m_tdata[0]), .m00_axis_tlast(m_tlast[0]), .m00_axis_tstrb(m_tstrb[0])
  );

  fm_discriminator #(
    .ANGLE_W(16), .OUT_W(16), .DECIM(4), .SHIFT(0), .MAG_THRESH(16'h0100)
  ) dut_b (
    .s00_axis_aclk(clk), .s00_axis_aresetn(rst_n[1]),
    .s00_axis_tvalid(s_tvalid[1]), .s00_axis_tready(s_tready[1]),
    .s00_axis_tdata(s_tdata[1]), .s00_axis_tlast(s_tlast[1]), .s00_axis_tstrb(s_tstrb),
    .m00_axis_tvalid(m_tvalid[1]), .m00_axis_tready(m_tready[1]),
    .m00_axis_tdata(m_tdata[1]), .m00_axis_tlast(m_tlast[1]), .m00_axis_tstrb(m_tstrb[1])
  );

  int errors = 0;
  int checks = 0;
  bit bp_rand = 1'b0;

  // Reference model state: group open flag, beats in group, running sum, last phase.
  bit          m_grp  [2];
  int          m_cnt  [2];
  int          m_sum  [2];
  logic [15:0] m_prev [2];
  bit          acc_seen [2];
  int expq0[$], expq1[$], obs0[$], obs1[$];

  function automatic int p_decim(int i);  return (i == 0) ? 1 : 4;      endfunction
  function automatic int p_shift(int i);  return (i == 0) ? 1 : 0;      endfunction
  function automatic int p_thresh(int i); return (i == 0) ? 0 : 'h100;  endfunction

  task automatic check(int i, string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL inst%0d %s: got %h want %h", i, name, act, exp);
    end
  endtask

  function automatic int qsize(int i);
    return (i == 0) ? expq0.size() : expq1.size();
  endfunction

  task automatic model_clear(int i);
    m_grp[i] = 1'b0; m_cnt[i] = 0; m_sum[i] = 0; m_prev[i] = 16'h0;
    if (i == 0) expq0.delete(); else expq1.delete();
  endtask

  task automatic model_beat(int i, logic [31:0] data, logic last);
    logic [15:0]        ph, mg;
    logic signed [15:0] d;
    int                 v, e;
    ph = data[31:16];
    mg = data[15:0];
    if (!m_grp[i]) begin
      m_grp[i] = 1'b1; m_cnt[i] = 1; m_sum[i] = 0;
    end else begin
      d = ph - m_prev[i];
      if (int'(mg) < p_thresh(i)) d = 16'sd0;
      m_sum[i] += int'(d);
      m_cnt[i]++;
    end
    m_prev[i] = ph;
    if (m_cnt[i] == p_decim(i) || last) begin
      v = m_sum[i] >>> p_shift(i);
      if (v > 32767)  v = 32767;
      if (v < -32768) v = -32768;
      e = ((last ? 1 : 0) << 16) | (v & 'hFFFF);
      if (i == 0) expq0.push_back(e); else expq1.push_back(e);
      m_cnt[i] = 0; m_sum[i] = 0;
      if (last) m_grp[i] = 1'b0;
    end
  endtask

  task automatic monitor(int i);
    int          e;
    logic [15:0] w;
    acc_seen[i] = 1'b0;
    if (!rst_n[i]) begin
      check(i, "rst_m_tvalid", 32'(m_tvalid[i]), 32'd0);
      check(i, "rst_m_tdata", m_tdata[i], 32'd0);
      check(i, "rst_m_tlast", 32'(m_tlast[i]), 32'd0);
      check(i, "rst_s_tready", 32'(s_tready[i]), 32'd0);
      model_clear(i);
      return;
    end
    if (m_tvalid[i]) check(i, "m_tstrb", 32'(m_tstrb[i]), 32'hF);
    if (m_tvalid[i] && m_tready[i]) begin
      if (qsize(i) == 0) begin
        checks++; errors++;
        $display("FAIL inst%0d extra_output: got %h want no word", i, m_tdata[i]);
      end else begin
        e = (i == 0) ? expq0.pop_front() : expq1.pop_front();
        w = e[15:0];
        check(i, "out_tdata", m_tdata[i], {{16{w[15]}}, w});
        check(i, "out_tlast", 32'(m_tlast[i]), 32'(e[16]));
      end
      e = {15'd0, m_tlast[i], m_tdata[i][15:0]};
      if (i == 0) obs0.push_back(e); else obs1.push_back(e);
    end
    if (s_tvalid[i] && s_tready[i]) begin
      model_beat(i, s_tdata[i], s_tlast[i]);
      acc_seen[i] = 1'b1;
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    monitor(0);
    monitor(1);
    @(posedge clk);
    #1;
    if (bp_rand) m_tready[1] = 1'($urandom_range(0, 1));
  endtask

  task automatic send(int i, logic [15:0] ph, logic [15:0] mg, logic last);
    int n;
    s_tvalid[i] = 1'b1;
    s_tdata[i]  = {ph, mg};
    s_tlast[i]  = last;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!acc_seen[i] && n < 50);
    if (!acc_seen[i]) begin
      checks++; errors++;
      $display("FAIL inst%0d send_timeout: got no accept want accept within 50 cycles", i);
    end
    s_tvalid[i] = 1'b0;
    s_tlast[i]  = 1'b0;
  endtask

  task automatic drain(int i);
    int n;
    n = 0;
    while (qsize(i) != 0 && n < 300) begin
      cyc();
      n++;
    end
    if (qsize(i) != 0) begin
      checks++; errors++;
      $display("FAIL inst%0d drain_timeout: got %0d pending want 0", i, qsize(i));
    end
    repeat (3) cyc();
  endtask

  task automatic check_obs(int i, int idx, int exp, string name);
    int v;
    v = -1;
    if (i == 0 && idx < obs0.size()) v = obs0[idx];
    if (i == 1 && idx < obs1.size()) v = obs1[idx];
    check(i, name, v, exp);
  endtask

  task automatic stream_basic();
    send(0, 16'h1000, 16'h1000, 1'b0);
    send(0, 16'h3000, 16'h1000, 1'b0);
    drain(0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got time limit want completion");
    $fatal(1);
  end

  initial begin
    int base, k, n;
    s_tstrb = 4'h5;
    for (int i = 0; i < 2; i++) begin
      rst_n[i] = 1'b0; s_tvalid[i] = 1'b0; s_tdata[i] = 32'h0;
      s_tlast[i] = 1'b0; m_tready[i] = 1'b1;
      model_clear(i);
    end
    repeat (3) cyc();
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    check(0, "tready_at_release", 32'(s_tready[0]), 32'd0);
    check(1, "tready_at_release", 32'(s_tready[1]), 32'd0);
    cyc();
    check(0, "tready_first_edge", 32'(s_tready[0]), 32'd1);
    check(1, "tready_first_edge", 32'(s_tready[1]), 32'd1);

    // Basic stream with latency check on the first group.
    send(0, 16'h0000, 16'h1000, 1'b0);
    check(0, "latency_cyc1_tvalid", 32'(m_tvalid[0]), 32'd0);
    cyc();
    check(0, "latency_cyc2_tvalid", 32'(m_tvalid[0]), 32'd1);
    stream_basic();
    check_obs(0, 0, 'h0000, "basic_out0");
    check_obs(0, 1, 'h0800, "basic_out1");
    check_obs(0, 2, 'h1000, "basic_out2");

    // Positive wrap across +pi.
    send(0, 16'h7000, 16'h1000, 1'b0);
    send(0, 16'h9000, 16'h1000, 1'b1);
    drain(0);
    check_obs(0, 3, 'h2000, "wrap_out0");
    check_obs(0, 4, 'h11000, "wrap_out1_last");

    // Output stalled: buffer fills, input stalls, everything delivered in order on release.
    base = obs0.size();
    m_tready[0] = 1'b0;
    k = 0;
    s_tvalid[0] = 1'b1;
    s_tdata[0]  = {16'(k * k * 'h300), 16'h1000};
    repeat (10) begin
      cyc();
      if (acc_seen[0]) begin
        k++;
        s_tdata[0] = {16'(k * k * 'h300), 16'h1000};
      end
    end
    check(0, "stall_tready", 32'(s_tready[0]), 32'd0);
    check(0, "stall_tvalid", 32'(m_tvalid[0]), 32'd1);
    check(0, "stall_accepted", k, 2);
    m_tready[0] = 1'b1;
    n = 0;
    while (k < 8 && n < 100) begin
      cyc();
      n++;
      if (acc_seen[0]) begin
        k++;
        s_tdata[0] = {16'(k * k * 'h300), 16'h1000};
      end
    end
    s_tvalid[0] = 1'b0;
    check(0, "stall_total_accepted", k, 8);
    drain(0);
    check_obs(0, base, 'h0000, "stall_out0");
    check_obs(0, base + 1, 'h0180, "stall_out1");

    // Reset in the middle of traffic, then the basic stream again.
    m_tready[0] = 1'b0;
    send(0, 16'h4000, 16'h1000, 1'b0);
    cyc();
    cyc();
    check(0, "pre_reset_tvalid", 32'(m_tvalid[0]), 32'd1);
    check(0, "pre_reset_tdata", m_tdata[0], 32'hFFFFD680);
    send(0, 16'h4800, 16'h1000, 1'b0);
    rst_n[0] = 1'b0;
    #1;
    check(0, "async_rst_tvalid", 32'(m_tvalid[0]), 32'd0);
    check(0, "async_rst_tdata", m_tdata[0], 32'd0);
    check(0, "async_rst_tlast", 32'(m_tlast[0]), 32'd0);
    check(0, "async_rst_tready", 32'(s_tready[0]), 32'd0);
    model_clear(0);
    repeat (3) cyc();
    m_tready[0] = 1'b1;
    rst_n[0] = 1'b1;
    check(0, "tready_at_rerelease", 32'(s_tready[0]), 32'd0);
    cyc();
    check(0, "tready_after_rerelease", 32'(s_tready[0]), 32'd1);
    base = obs0.size();
    send(0, 16'h0000, 16'h1000, 1'b0);
    stream_basic();
    check_obs(0, base, 'h0000, "post_rst_out0");
    check_obs(0, base + 1, 'h0800, "post_rst_out1");
    check_obs(0, base + 2, 'h1000, "post_rst_out2");

    // Decimating instance under random output backpressure.
    bp_rand = 1'b1;
    send(1, 16'h0000, 16'h1000, 1'b0);
    send(1, 16'h1000, 16'h1000, 1'b0);
    send(1, 16'h2000, 16'h0080, 1'b0);
    send(1, 16'h3000, 16'h0100, 1'b0);
    send(1, 16'h4000, 16'h1000, 1'b0);
    send(1, 16'h5000, 16'h1000, 1'b1);
    send(1, 16'h0000, 16'h1000, 1'b0);
    send(1, 16'h7000, 16'h1000, 1'b0);
    send(1, 16'hE000, 16'h1000, 1'b0);
    send(1, 16'h5000, 16'h1000, 1'b0);
    send(1, 16'h5800, 16'h1000, 1'b0);
    send(1, 16'h6000, 16'h1000, 1'b1);
    send(1, 16'h0100, 16'h1000, 1'b1);
    send(1, 16'h0000, 16'h1000, 1'b0);
    send(1, 16'h9000, 16'h1000, 1'b0);
    send(1, 16'h2000, 16'h1000, 1'b0);
    send(1, 16'hB000, 16'h1000, 1'b0);
    drain(1);
    bp_rand = 1'b0;
    m_tready[1] = 1'b1;
    check(1, "decim_out_count", obs1.size(), 6);
    check_obs(1, 0, 'h02000, "squelch_group");
    check_obs(1, 1, 'h12000, "partial_after_squelch");
    check_obs(1, 2, 'h07FFF, "pos_saturate");
    check_obs(1, 3, 'h11000, "partial_tlast");
    check_obs(1, 4, 'h10000, "reprime_single");
    check_obs(1, 5, 'h08000, "neg_saturate");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
